// File: rtl/frame_sync_lock_if.sv
// Sync-marker input and lock/position outputs exchanged between the sequence detector side and the deframer side.
interface frame_sync_lock_if #(
    parameter int PW = 4
);
    logic          seen;
    logic          locked;
    logic          frame_start;
    logic [PW-1:0] bit_pos;
    logic          lock_lost;
    logic          slip;
    logic [15:0]   match_cnt;

    modport master (
        output seen,
        input  locked, frame_start, bit_pos, lock_lost, slip, match_cnt
    );

    modport slave (
        input  seen,
        output locked, frame_start, bit_pos, lock_lost, slip, match_cnt
    );
endinterface

// File: rtl/frame_sync_lock.sv
// Frame-sync lock FSM: hunts for periodic sync markers, verifies them, then flywheels through isolated misses.
// Define FSYNC_SLIP_TOL_EN for a +/-1 cycle tolerance window while locked, with a slip pulse on realignment.
module frame_sync_lock #(
    parameter int FRAME_LEN = 16,
    parameter int LOCK_CNT  = 3,
    parameter int MISS_CNT  = 2,
    parameter int PW        = $clog2(FRAME_LEN)
) (
    input logic              clk,
    input logic              resetn,
    frame_sync_lock_if.slave bus
);
    // state     | meaning
    // ST_HUNT   | no phase reference, waiting for any marker
    // ST_VERIFY | phase anchored, counting consecutive in-phase markers
    // ST_LOCKED | lock declared, tracking phase and tolerating misses
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [PW-1:0] PH_LAST        = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] PH_ONE         = PW'(1);
    localparam logic [15:0]   LOCK_TGT       = 16'(LOCK_CNT);
    localparam logic [15:0]   MISS_TGT       = 16'(MISS_CNT);
    localparam bit            LOCK_IMMEDIATE = (LOCK_CNT == 1);

    state_t        state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [15:0]   hit_cnt_q, hit_cnt_d;
    logic [15:0]   miss_cnt_q, miss_cnt_d;
    logic [15:0]   match_cnt_q, match_cnt_d;
    logic          lock_lost_q, lock_lost_d;
    logic [15:0]   hit_inc, miss_inc, match_inc;
    logic          ph_zero, take_miss;
`ifdef FSYNC_SLIP_TOL_EN
    logic          win_hit_q, win_hit_d;
    logic          slip_q, slip_d;
    logic          in_win;
`endif

    always_comb begin
        ph_zero     = (ph_q == '0);
        hit_inc     = hit_cnt_q + 16'd1;
        miss_inc    = miss_cnt_q + 16'd1;
        match_inc   = (match_cnt_q == 16'hFFFF) ? match_cnt_q : match_cnt_q + 16'd1;
        state_d     = state_q;
        ph_d        = (ph_q == PH_LAST) ? '0 : ph_q + PH_ONE;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        match_cnt_d = match_cnt_q;
        lock_lost_d = 1'b0;
        take_miss   = 1'b0;
`ifdef FSYNC_SLIP_TOL_EN
        win_hit_d   = win_hit_q;
        slip_d      = 1'b0;
        in_win      = (ph_q == PH_LAST) || ph_zero || (ph_q == PH_ONE);
`endif
        case (state_q)
            ST_HUNT: begin
                if (bus.seen) begin
                    ph_d      = PH_ONE;
                    hit_cnt_d = 16'd1;
                    if (LOCK_IMMEDIATE) begin
                        state_d    = ST_LOCKED;
                        miss_cnt_d = '0;
`ifdef FSYNC_SLIP_TOL_EN
                        win_hit_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                if (ph_zero) begin
                    if (bus.seen) begin
                        hit_cnt_d = hit_inc;
                        if (hit_inc == LOCK_TGT) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
`ifdef FSYNC_SLIP_TOL_EN
                            win_hit_d  = 1'b1;
`endif
                        end
                    end else begin
                        state_d   = ST_HUNT;
                        hit_cnt_d = '0;
                    end
                end else if (bus.seen) begin
                    ph_d      = PH_ONE;
                    hit_cnt_d = 16'd1;
                end
            end
            ST_LOCKED: begin
`ifdef FSYNC_SLIP_TOL_EN
                // The window closes at ph==1; a late hit re-anchors to ph==1 again, so the flag blocks double counting.
                if (bus.seen && in_win && !win_hit_q) begin
                    ph_d        = PH_ONE;
                    miss_cnt_d  = '0;
                    match_cnt_d = match_inc;
                    win_hit_d   = 1'b1;
                    slip_d      = !ph_zero;
                end else if (ph_q == PH_ONE) begin
                    win_hit_d = 1'b0;
                    take_miss = !win_hit_q;
                end
`else
                if (ph_zero) begin
                    if (bus.seen) begin
                        miss_cnt_d  = '0;
                        match_cnt_d = match_inc;
                    end else begin
                        take_miss = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_d    = ST_HUNT;
                ph_d       = '0;
                hit_cnt_d  = '0;
                miss_cnt_d = '0;
            end
        endcase

        if (take_miss) begin
            if (miss_inc == MISS_TGT) begin
                state_d     = ST_HUNT;
                lock_lost_d = 1'b1;
                ph_d        = '0;
                hit_cnt_d   = '0;
                miss_cnt_d  = '0;
            end else begin
                miss_cnt_d = miss_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_HUNT;
            ph_q        <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            match_cnt_q <= '0;
            lock_lost_q <= 1'b0;
`ifdef FSYNC_SLIP_TOL_EN
            win_hit_q   <= 1'b0;
            slip_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            match_cnt_q <= match_cnt_d;
            lock_lost_q <= lock_lost_d;
`ifdef FSYNC_SLIP_TOL_EN
            win_hit_q   <= win_hit_d;
            slip_q      <= slip_d;
`endif
        end
    end

    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.frame_start = (state_q == ST_LOCKED) && (ph_q == '0);
    assign bus.bit_pos     = (state_q == ST_LOCKED) ? ph_q : '0;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.match_cnt   = match_cnt_q;
`ifdef FSYNC_SLIP_TOL_EN
    assign bus.slip        = slip_q;
`else
    assign bus.slip        = 1'b0;
`endif
endmodule

// File: tb/tb_frame_sync_lock.sv
// Directed bench for frame_sync_lock: expectations are queued per cycle and checked as the DUT reaches them.
module tb_frame_sync_lock;
    localparam int FRAME_LEN = 8;
    localparam int LOCK_CNT  = 3;
    localparam int MISS_CNT  = 2;
    localparam int PW        = 3;

    logic clk = 1'b0;
    logic resetn;

    frame_sync_lock_if #(.PW(PW)) bus ();

    frame_sync_lock #(
        .FRAME_LEN(FRAME_LEN),
        .LOCK_CNT (LOCK_CNT),
        .MISS_CNT (MISS_CNT),
        .PW       (PW)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic        locked;
        logic [31:0] bit_pos;
        logic        fs;
        logic        ll;
        logic        slip;
        logic [31:0] mc;
    } exp_t;

    exp_t sb_q[$];
    bit   seen_at[int];
    int   cyc;
    int   total;
    int   bad;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic l, input logic [31:0] bp, input logic fs,
                             input logic ll, input logic sl, input logic [31:0] mc);
        cmp({tag, ".locked"},      32'(bus.locked),      32'(l));
        cmp({tag, ".bit_pos"},     32'(bus.bit_pos),     bp);
        cmp({tag, ".frame_start"}, 32'(bus.frame_start), 32'(fs));
        cmp({tag, ".lock_lost"},   32'(bus.lock_lost),   32'(ll));
        cmp({tag, ".slip"},        32'(bus.slip),        32'(sl));
        cmp({tag, ".match_cnt"},   32'(bus.match_cnt),   mc);
    endtask

    task automatic expect_at(input int c, input string tag, input logic l, input int bp, input logic fs,
                             input logic ll, input logic sl, input int mc);
        exp_t e;
        e.cyc = c; e.tag = tag; e.locked = l; e.bit_pos = 32'(bp);
        e.fs = fs; e.ll = ll; e.slip = sl; e.mc = 32'(mc);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) cmp({e.tag, ".cycle"}, 32'(cyc), 32'(e.cyc));
            else check_all(e.tag, e.locked, e.bit_pos, e.fs, e.ll, e.slip, e.mc);
        end
    endtask

    task automatic tick();
        bus.seen = (seen_at.exists(cyc) != 0);
        @(posedge clk);
        #1;
        cyc++;
        drain();
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic seg_end(input string tag);
        cmp({tag, ".pending"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        bus.seen = 1'b0;
        seen_at.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        bus.seen = 1'b0;
        resetn = 1'b1;
        #2 resetn = 1'b0;

        // Reset held with seen toggling: everything stays cleared.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.seen = ~bus.seen;
        end
        @(negedge clk);
        check_all("rst_hold", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        bus.seen = 1'b0;
        resetn = 1'b1;
        cyc = 0;
        expect_at(50, "idle", 0, 0, 0, 0, 0, 0);
        run_until(50);
        seg_end("idle");

        // Lock acquisition; the completing marker does not bump match_cnt.
        do_reset();
        seen_at[10] = 1; seen_at[18] = 1; seen_at[26] = 1; seen_at[34] = 1;
        expect_at(26, "acq_vfy",   0, 0, 0, 0, 0, 0);
        expect_at(27, "acq_rise",  1, 1, 0, 0, 0, 0);
        expect_at(34, "acq_fs34",  1, 0, 1, 0, 0, 0);
        expect_at(35, "acq_mc1",   1, 1, 0, 0, 0, 1);
        expect_at(42, "acq_fs42",  1, 0, 1, 0, 0, 1);
        expect_at(43, "acq_fly",   1, 1, 0, 0, 0, 1);
        run_until(43);
        seg_end("acq");

        // Out-of-phase marker in VERIFY re-anchors.
        do_reset();
        seen_at[10] = 1; seen_at[18] = 1; seen_at[25] = 1; seen_at[33] = 1; seen_at[41] = 1;
        expect_at(27, "ra_27",  0, 0, 0, 0, 0, 0);
        expect_at(41, "ra_41",  0, 0, 0, 0, 0, 0);
        expect_at(42, "ra_42",  1, 1, 0, 0, 0, 0);
        expect_at(49, "ra_fs",  1, 0, 1, 0, 0, 0);
        run_until(49);
        seg_end("ra");

        // Flywheel through one miss, then two consecutive misses drop lock.
        do_reset();
        seen_at[26] = 1; seen_at[34] = 1; seen_at[42] = 1; seen_at[50] = 1; seen_at[66] = 1;
        expect_at(43, "fw_lock", 1, 1, 0, 0, 0, 0);
        expect_at(51, "fw_mc1",  1, 1, 0, 0, 0, 1);
        expect_at(58, "fw_fs58", 1, 0, 1, 0, 0, 1);
        expect_at(59, "fw_miss", 1, 1, 0, 0, 0, 1);
        expect_at(67, "fw_mc2",  1, 1, 0, 0, 0, 2);
        expect_at(75, "fw_m1",   1, 1, 0, 0, 0, 2);
        expect_at(82, "fw_fs82", 1, 0, 1, 0, 0, 2);
`ifdef FSYNC_SLIP_TOL_EN
        expect_at(83, "fw_83",   1, 1, 0, 0, 0, 2);
        expect_at(84, "fw_lost", 0, 0, 0, 1, 0, 2);
        expect_at(85, "fw_post", 0, 0, 0, 0, 0, 2);
`else
        expect_at(83, "fw_lost", 0, 0, 0, 1, 0, 2);
        expect_at(84, "fw_post", 0, 0, 0, 0, 0, 2);
`endif
        run_until(86);
        seg_end("fw");

        // Asynchronous reset while locked clears outputs before the next edge, no lock_lost.
        do_reset();
        seen_at[10] = 1; seen_at[18] = 1; seen_at[26] = 1; seen_at[34] = 1;
        seen_at[42] = 1; seen_at[50] = 1; seen_at[58] = 1; seen_at[66] = 1;
        run_until(70);
        check_all("pre_arst", 1'b1, 4, 1'b0, 1'b0, 1'b0, 5);
        #2 resetn = 1'b0;
        #1 check_all("arst", 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        bus.seen = 1'b0;
        seen_at.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cyc = 0;
        expect_at(1, "post_arst1", 0, 0, 0, 0, 0, 0);
        expect_at(2, "post_arst2", 0, 0, 0, 0, 0, 0);
        expect_at(3, "post_arst3", 0, 0, 0, 0, 0, 0);
        run_until(3);
        seg_end("arst");

        // Marker one cycle late: tolerated as a slip, or counted as a miss in exact mode.
        do_reset();
        seen_at[10] = 1; seen_at[18] = 1; seen_at[26] = 1; seen_at[34] = 1; seen_at[42] = 1; seen_at[51] = 1;
`ifdef FSYNC_SLIP_TOL_EN
        expect_at(52, "sl_slip", 1, 1, 0, 0, 1, 3);
        expect_at(53, "sl_53",   1, 2, 0, 0, 0, 3);
        expect_at(59, "sl_fs",   1, 0, 1, 0, 0, 3);
`else
        expect_at(52, "sl_miss", 1, 2, 0, 0, 0, 2);
        expect_at(58, "sl_fs",   1, 0, 1, 0, 0, 2);
        expect_at(59, "sl_lost", 0, 0, 0, 1, 0, 2);
`endif
        run_until(60);
        seg_end("sl");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
